// File: rtl/rr_decode_arbiter_if.sv
// Handshake bundle between the requesting units and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_decode_arbiter_if #(
   parameter int N     = 32,
   parameter int IDX_W = 5
);
   logic [N-1:0]     iReq;
   logic             iDone;
   logic [IDX_W-1:0] oGntIdx;
   logic             oGntEna;
   logic [N-1:0]     oGnt;
   logic             oTimeout;

   modport master (
      output iReq,
      output iDone,
      input  oGntIdx,
      input  oGntEna,
      input  oGnt,
      input  oTimeout
   );

   modport slave (
      input  iReq,
      input  iDone,
      output oGntIdx,
      output oGntEna,
      output oGnt,
      output oTimeout
   );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter: picks a winner index, holds it until done/withdraw/timeout,
// inserts one dead cycle, then re-arbitrates. The grant is a one-hot decode of the index.
module rr_decode_arbiter #(
   parameter int N        = 32,
   parameter int IDX_W    = 5,
   parameter int MAX_HOLD = 16
) (
   input logic               iClk,
   input logic               iRst_n,
   rr_decode_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam int PAD_W = 1 << IDX_W;

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arbStateT;

   arbStateT         stateReg, stateNext;
   logic [IDX_W-1:0] gntIdxReg, gntIdxNext;
   logic             gntEnaReg, gntEnaNext;
   logic [CNT_W-1:0] holdCntReg, holdCntNext;
   logic [IDX_W-1:0] lastReg, lastNext;
   logic             timeoutPulse;

   logic [PAD_W-1:0] reqPad;
   logic [IDX_W-1:0] winner;
   logic             anyReq;
   logic [IDX_W:0]   scanIdx;

   // Widen to a power of two so any index value is a legal bit select.
   assign reqPad = PAD_W'(bus.iReq);

   // Scan from the farthest offset down so the nearest requester after lastReg wins.
   always_comb begin
      winner  = '0;
      anyReq  = 1'b0;
      scanIdx = '0;
      for (int off = N; off >= 1; off--) begin
         scanIdx = {1'b0, lastReg} + (IDX_W + 1)'(off);
         if (scanIdx >= (IDX_W + 1)'(N)) begin
            scanIdx = scanIdx - (IDX_W + 1)'(N);
         end
         if (reqPad[scanIdx[IDX_W-1:0]]) begin
            winner = scanIdx[IDX_W-1:0];
            anyReq = 1'b1;
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         stateReg   <= IDLE;
         gntIdxReg  <= '0;
         gntEnaReg  <= 1'b0;
         holdCntReg <= '0;
         lastReg    <= IDX_W'(N - 1);
      end else begin
         stateReg   <= stateNext;
         gntIdxReg  <= gntIdxNext;
         gntEnaReg  <= gntEnaNext;
         holdCntReg <= holdCntNext;
         lastReg    <= lastNext;
      end
   end

   always_comb begin
      stateNext    = stateReg;
      gntIdxNext   = gntIdxReg;
      gntEnaNext   = gntEnaReg;
      holdCntNext  = holdCntReg;
      lastNext     = lastReg;
      timeoutPulse = 1'b0;
      case (stateReg)
         IDLE: begin
            if (anyReq) begin
               stateNext   = GRANT;
               gntIdxNext  = winner;
               gntEnaNext  = 1'b1;
               lastNext    = winner;
               holdCntNext = CNT_W'(1);
            end
         end
         GRANT: begin
            // An explicit release or withdrawal masks a coincident timeout.
            if (bus.iDone || !reqPad[gntIdxReg]) begin
               stateNext   = RELEASE;
               gntEnaNext  = 1'b0;
               holdCntNext = '0;
            end else if (holdCntReg == CNT_W'(MAX_HOLD)) begin
               stateNext    = RELEASE;
               gntEnaNext   = 1'b0;
               holdCntNext  = '0;
               timeoutPulse = 1'b1;
            end else begin
               holdCntNext = holdCntReg + CNT_W'(1);
            end
         end
         RELEASE: begin
            stateNext   = IDLE;
            gntEnaNext  = 1'b0;
            holdCntNext = '0;
         end
         default: begin
            stateNext  = IDLE;
            gntEnaNext = 1'b0;
         end
      endcase
   end

   assign bus.oGntIdx  = gntIdxReg;
   assign bus.oGntEna  = gntEnaReg;
   assign bus.oTimeout = timeoutPulse;

   // Decode straight from registers so the grant cannot glitch to another owner.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : gGntDecode
         assign bus.oGnt[gi] = gntEnaReg && (gntIdxReg == IDX_W'(gi));
      end
   endgenerate
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed scenarios plus random traffic, every cycle
// compared against a behavioural owner/pointer model.
module tb_rr_decode_arbiter;
   localparam int N        = 32;
   localparam int IDX_W    = 5;
   localparam int MAX_HOLD = 16;

   logic iClk = 1'b0;
   logic iRst_n;
   always #5 iClk = ~iClk;

   rr_decode_arbiter_if #(.N(N), .IDX_W(IDX_W)) bus ();

   rr_decode_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
      .iClk  (iClk),
      .iRst_n(iRst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the resource, how long, and who won last.
   int owner;
   int held;
   int lastWinner;
   int lastIdx;
   bit deadCycle;

   logic             obsEna;
   logic             obsTo;
   logic [IDX_W-1:0] obsIdx;
   logic [N-1:0]     obsGnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      owner      = -1;
      held       = 0;
      lastWinner = N - 1;
      lastIdx    = 0;
      deadCycle  = 1'b0;
   endtask

   task automatic modelAdvance(input logic [N-1:0] req, input logic done);
      if (owner >= 0) begin
         if (done || !req[owner] || held == MAX_HOLD) begin
            owner     = -1;
            held      = 0;
            deadCycle = 1'b1;
         end else begin
            held++;
         end
      end else if (deadCycle) begin
         deadCycle = 1'b0;
      end else if (req != '0) begin
         for (int k = 1; k <= N; k++) begin
            if (req[(lastWinner + k) % N]) begin
               owner = (lastWinner + k) % N;
               break;
            end
         end
         lastWinner = owner;
         lastIdx    = owner;
         held       = 1;
      end
   endtask

   // One clock: drive, compare at negedge, advance the model on the rising edge.
   task automatic cycle(input logic [N-1:0] req, input logic done);
      logic [N-1:0] expGnt;
      logic         expTo;
      bus.iReq  = req;
      bus.iDone = done;
      @(negedge iClk);
      expGnt = (owner >= 0) ? (N'(1) << owner) : '0;
      expTo  = (owner >= 0) && (held == MAX_HOLD) && !done && req[owner];
      obsEna = bus.oGntEna;
      obsTo  = bus.oTimeout;
      obsIdx = bus.oGntIdx;
      obsGnt = bus.oGnt;
      check("ena", 32'(obsEna), 32'(owner >= 0));
      check("gnt", 32'(obsGnt), 32'(expGnt));
      check("idx", 32'(obsIdx), 32'(lastIdx));
      check("timeout", 32'(obsTo), 32'(expTo));
      check("onehot0", 32'($onehot0(obsGnt)), 32'd1);
      @(posedge iClk);
      modelAdvance(req, done);
      #1;
   endtask

   // Request until granted, release with iDone in the granted cycle.
   task automatic grantOnce(input logic [N-1:0] req, output logic [IDX_W-1:0] idx,
                            output logic [N-1:0] gnt, output bit ok);
      ok  = 1'b0;
      idx = '0;
      gnt = '0;
      for (int t = 0; t < 12; t++) begin
         cycle(req, owner >= 0);
         if (obsEna) begin
            idx = obsIdx;
            gnt = obsGnt;
            ok  = 1'b1;
            break;
         end
      end
   endtask

   task automatic settle();
      for (int t = 0; t < 3; t++) cycle('0, 1'b0);
   endtask

   initial begin
      logic [IDX_W-1:0] gIdx;
      logic [N-1:0]     gGnt;
      logic [N-1:0]     oneBit;
      logic [N-1:0]     rndReq;
      bit               ok;
      int               expRot[4];
      int               run, toCnt, toPos, gapCnt, phase, cnt;

      bus.iReq  = '0;
      bus.iDone = 1'b0;
      iRst_n    = 1'b0;
      modelReset();
      repeat (2) @(posedge iClk);
      #1;
      check("rst_ena", 32'(bus.oGntEna), 32'd0);
      check("rst_gnt", 32'(bus.oGnt), 32'd0);
      check("rst_idx", 32'(bus.oGntIdx), 32'd0);
      check("rst_to", 32'(bus.oTimeout), 32'd0);
      @(negedge iClk);
      iRst_n = 1'b1;
      @(posedge iClk);
      #1;

      // Reset: first grant goes to requester 0, then reset mid-GRANT clears at once.
      cycle(32'hFFFF_FFFF, 1'b0);
      cycle(32'hFFFF_FFFF, 1'b0);
      check("first_idx", 32'(obsIdx), 32'd0);
      check("first_gnt", 32'(obsGnt), 32'h1);
      iRst_n    = 1'b0;
      bus.iReq  = '0;
      #1;
      check("async_ena", 32'(bus.oGntEna), 32'd0);
      check("async_gnt", 32'(bus.oGnt), 32'd0);
      modelReset();
      @(posedge iClk);
      @(negedge iClk);
      iRst_n = 1'b1;
      @(posedge iClk);
      #1;

      // Rotation across 0, 4, 31 and back to 0.
      expRot = '{0, 4, 31, 0};
      for (int g = 0; g < 4; g++) begin
         grantOnce(32'h8000_0011, gIdx, gGnt, ok);
         check("rot_granted", 32'(ok), 32'd1);
         check("rot_winner", 32'(gIdx), 32'(expRot[g]));
      end

      // Wrap: pointer at 31, requesters 1 and 2 -> 1 wins.
      settle();
      grantOnce(32'h8000_0000, gIdx, gGnt, ok);
      check("wrap_pre", 32'(gIdx), 32'd31);
      cycle('0, 1'b0);
      grantOnce(32'h0000_0006, gIdx, gGnt, ok);
      check("wrap_idx", 32'(gIdx), 32'd1);
      check("wrap_gnt", 32'(gGnt), 32'h2);

      // Timeout: hold 16 cycles, pulse on the 16th, two idle cycles, regrant 8.
      settle();
      run = 0; toCnt = 0; toPos = 0; gapCnt = 0; phase = 0; gIdx = '0;
      for (int t = 0; t < 60 && phase < 3; t++) begin
         cycle(32'h100, 1'b0);
         if (phase == 0 && obsEna) phase = 1;
         if (phase == 1) begin
            if (obsEna) begin
               run++;
               if (obsTo) begin
                  toCnt++;
                  toPos = run;
               end
            end else begin
               phase = 2;
            end
         end
         if (phase == 2) begin
            if (obsEna) begin
               gIdx  = obsIdx;
               phase = 3;
            end else begin
               gapCnt++;
            end
         end
      end
      check("to_reached", 32'(phase), 32'd3);
      check("to_run", 32'(run), 32'd16);
      check("to_count", 32'(toCnt), 32'd1);
      check("to_pos", 32'(toPos), 32'd16);
      check("to_gap", 32'(gapCnt), 32'd2);
      check("to_regrant", 32'(gIdx), 32'd8);
      cycle(32'h100, 1'b1);
      settle();

      // Withdraw: owner 3 drops its request -> grant gone one cycle later.
      for (int t = 0; t < 6; t++) begin
         cycle(32'h8, 1'b0);
         if (obsEna) break;
      end
      check("wd_owner", 32'(obsIdx), 32'd3);
      cycle(32'h8, 1'b0);
      cycle('0, 1'b0);
      check("wd_still", 32'(obsEna), 32'd1);
      cycle('0, 1'b0);
      check("wd_released", 32'(obsEna), 32'd0);
      settle();

      // Done coinciding with the 16th cycle: release without a timeout pulse.
      cnt = 0;
      for (int t = 0; t < 40; t++) begin
         cycle(32'h8, cnt == MAX_HOLD - 1);
         if (obsEna) begin
            cnt++;
            if (cnt == MAX_HOLD) break;
         end
      end
      check("sim_cnt", 32'(cnt), 32'(MAX_HOLD));
      check("sim_to", 32'(obsTo), 32'd0);
      cycle(32'h8, 1'b0);
      check("sim_rel", 32'(obsEna), 32'd0);
      settle();

      // Exhaustive decode of every index.
      for (int i = 0; i < N; i++) begin
         oneBit = N'(1) << i;
         grantOnce(oneBit, gIdx, gGnt, ok);
         check("dec_idx", 32'(gIdx), 32'(i));
         check("dec_gnt", 32'(gGnt), 32'(oneBit));
         cycle('0, 1'b0);
      end
      settle();

      // Random traffic: slowly changing request sets, occasional done.
      rndReq = '0;
      for (int t = 0; t < 800; t++) begin
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 2))
               0: rndReq = N'($urandom());
               1: rndReq = N'($urandom() & $urandom() & $urandom());
               default: rndReq = N'(1) << $urandom_range(0, N - 1);
            endcase
         end
         cycle(rndReq, (owner >= 0) && ($urandom_range(0, 7) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
